// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Purpose  : RV32I instruction decode stage with a valid/ready handshake on
//             both sides. It has an output register and a one-entry skid
//             register, so in_ready is a registered signal and throughput is
//             one instruction per cycle.
//  Revision : 1.0 - initial release
//
//  Parameters
//    XLEN       width of pc_in / pc_out / imm (32 or more)
//    EN_SYSTEM  1: FENCE and SYSTEM decode as legal no-ops, 0: illegal
//  Ports
//    clk, rst       clock (rising edge), asynchronous active-high reset
//    flush          synchronous clear; drops every bundle held in the stage
//    in_valid       upstream instruction present
//    in_ready       stage can accept an instruction (registered)
//    instr, pc_in   instruction word and its address
//    out_valid      decoded bundle present
//    out_ready      downstream accepts the bundle
//    pc_out         address carried with the bundle
//    a0 / a1 / a2   rs1 / rs2 / rd fields
//    imm            format-selected immediate
//    func           {funct7, funct3}, zeroed where the opcode has none
//    en_*           control enables
//    ld_code        writeback source (NO/ALU/MEM/IMM/PC/PC+IMM)
//    illegal        unsupported opcode
// ============================================================================
module decode_stage #(
  parameter int XLEN      = 32,
  parameter bit EN_SYSTEM = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      a0,
  output logic [4:0]      a1,
  output logic [4:0]      a2,
  output logic [XLEN-1:0] imm,
  output logic [9:0]      func,
  output logic            en_jmp,
  output logic            en_uncond_jmp,
  output logic            en_rel_reg_jmp,
  output logic            en_imm,
  output logic            en_reg_wr,
  output logic            en_mem_wr,
  output logic [2:0]      ld_code,
  output logic            illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] LD_NO    = 3'b000;
  localparam logic [2:0] LD_ALU   = 3'b001;
  localparam logic [2:0] LD_MEM   = 3'b010;
  localparam logic [2:0] LD_IMM   = 3'b011;
  localparam logic [2:0] LD_PC    = 3'b100;
  localparam logic [2:0] LD_PCIMM = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      a0;
    logic [4:0]      a1;
    logic [4:0]      a2;
    logic [XLEN-1:0] imm;
    logic [9:0]      func;
    logic            en_jmp;
    logic            en_uncond_jmp;
    logic            en_rel_reg_jmp;
    logic            en_imm;
    logic            en_reg_wr;
    logic            en_mem_wr;
    logic [2:0]      ld_code;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [9:0]      w_func_full;
  logic [2:0]      w_funct3;
  bundle_t         w_dec;

  // Size casts of signed values sign-extend; the U immediate is cast from an
  // unsigned value and therefore zero-extends.
  assign w_imm_i = XLEN'($signed(instr[31:20]));
  assign w_imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign w_imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                  instr[11:8], 1'b0}));
  assign w_imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                  instr[30:21], 1'b0}));
  assign w_imm_u = XLEN'({instr[31:12], 12'b0});

  assign w_funct3    = instr[14:12];
  assign w_func_full = {instr[31:25], instr[14:12]};

  always_comb begin : p_decode
    w_dec    = '0;
    w_dec.pc = pc_in;
    w_dec.a0 = instr[19:15];
    w_dec.a1 = instr[24:20];
    w_dec.a2 = instr[11:7];
    if (instr[1:0] != 2'b11) begin
      w_dec.illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OP_LUI: begin
          w_dec.imm       = w_imm_u;
          w_dec.ld_code   = LD_IMM;
          w_dec.en_reg_wr = 1'b1;
        end
        OP_AUIPC: begin
          w_dec.imm       = w_imm_u;
          w_dec.ld_code   = LD_PCIMM;
          w_dec.en_reg_wr = 1'b1;
        end
        OP_JAL: begin
          w_dec.imm           = w_imm_j;
          w_dec.ld_code       = LD_PC;
          w_dec.en_jmp        = 1'b1;
          w_dec.en_uncond_jmp = 1'b1;
          w_dec.en_imm        = 1'b1;
          w_dec.en_reg_wr     = 1'b1;
        end
        OP_JALR: begin
          w_dec.imm            = w_imm_i;
          w_dec.func           = w_func_full;
          w_dec.ld_code        = LD_PC;
          w_dec.en_jmp         = 1'b1;
          w_dec.en_rel_reg_jmp = 1'b1;
          w_dec.en_imm         = 1'b1;
          w_dec.en_reg_wr      = 1'b1;
        end
        OP_LOAD: begin
          w_dec.imm       = w_imm_i;
          w_dec.ld_code   = LD_MEM;
          w_dec.en_imm    = 1'b1;
          w_dec.en_reg_wr = 1'b1;
        end
        OP_STORE: begin
          w_dec.imm       = w_imm_s;
          w_dec.en_imm    = 1'b1;
          w_dec.en_mem_wr = 1'b1;
        end
        OP_BRANCH: begin
          w_dec.imm    = w_imm_b;
          w_dec.func   = w_func_full;
          w_dec.en_jmp = 1'b1;
        end
        OP_OPIMM: begin
          w_dec.imm       = w_imm_i;
          w_dec.ld_code   = LD_ALU;
          w_dec.en_imm    = 1'b1;
          w_dec.en_reg_wr = 1'b1;
          // Only the shift-immediates carry a meaningful funct7.
          if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
            w_dec.func = w_func_full;
          end else begin
            w_dec.func = {7'b0, w_funct3};
          end
        end
        OP_OP: begin
          w_dec.func      = w_func_full;
          w_dec.ld_code   = LD_ALU;
          w_dec.en_reg_wr = 1'b1;
        end
        OP_FENCE, OP_SYSTEM: begin
          w_dec.illegal = !EN_SYSTEM;
        end
        default: begin
          w_dec.illegal = 1'b1;
        end
      endcase
    end
    // Writes to x0 are discarded for every opcode.
    w_dec.en_reg_wr = w_dec.en_reg_wr & (|instr[11:7]);
  end

  // --------------------------------------------------------------------------
  // Handshake state machine
  // --------------------------------------------------------------------------
  state_t  r_state, w_state_nxt;
  bundle_t r_out, r_skid;
  logic    r_out_valid, r_in_ready;
  logic    w_in_fire, w_out_fire;
  logic    w_load_out_in, w_load_out_skid, w_load_skid;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin : p_state
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin : p_next
    w_state_nxt     = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt   = S_ONE;
            w_load_out_in = 1'b1;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_out_in = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = S_FULL;
            w_load_skid = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only the drain can happen.
          if (w_out_fire) begin
            w_state_nxt     = S_ONE;
            w_load_out_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // Handshake flags are registered from the next state so both outputs come
  // straight from flops.
  always_ff @(posedge clk or posedge rst) begin : p_flags
    if (rst) begin
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_out_valid <= (w_state_nxt != S_EMPTY);
      r_in_ready  <= (w_state_nxt != S_FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_data
    if (rst) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_out_in) begin
        r_out <= w_dec;
      end else if (w_load_out_skid) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = r_out_valid;
  assign pc_out         = r_out.pc;
  assign a0             = r_out.a0;
  assign a1             = r_out.a1;
  assign a2             = r_out.a2;
  assign imm            = r_out.imm;
  assign func           = r_out.func;
  assign en_jmp         = r_out.en_jmp;
  assign en_uncond_jmp  = r_out.en_uncond_jmp;
  assign en_rel_reg_jmp = r_out.en_rel_reg_jmp;
  assign en_imm         = r_out.en_imm;
  assign en_reg_wr      = r_out.en_reg_wr;
  assign en_mem_wr      = r_out.en_mem_wr;
  assign ld_code        = r_out.ld_code;
  assign illegal        = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Purpose  : Self-checking bench for decode_stage. A driver issues directed
//             and random instructions and pushes the expected bundle of every
//             accepted instruction into a queue; a monitor pops and compares
//             whenever the stage completes a bundle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] pc_out;
  logic [4:0]      a0, a1, a2;
  logic [XLEN-1:0] imm;
  logic [9:0]      func;
  logic            en_jmp, en_uncond_jmp, en_rel_reg_jmp, en_imm, en_reg_wr, en_mem_wr;
  logic [2:0]      ld_code;
  logic            illegal;

  decode_stage #(.XLEN(XLEN), .EN_SYSTEM(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .a0(a0), .a1(a1), .a2(a2),
    .imm(imm), .func(func),
    .en_jmp(en_jmp), .en_uncond_jmp(en_uncond_jmp), .en_rel_reg_jmp(en_rel_reg_jmp),
    .en_imm(en_imm), .en_reg_wr(en_reg_wr), .en_mem_wr(en_mem_wr),
    .ld_code(ld_code), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  a0, a1, a2;
    logic [31:0] imm;
    logic [9:0]  func;
    logic [5:0]  en;      // {jmp, uncond, rel_reg, imm, reg_wr, mem_wr}
    logic [2:0]  ld;
    logic        ill;
    logic        chk_fi;  // func/imm defined for this opcode
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [5:0]  dut_en;
  logic [98:0] cur_bundle;
  assign dut_en     = {en_jmp, en_uncond_jmp, en_rel_reg_jmp, en_imm, en_reg_wr, en_mem_wr};
  assign cur_bundle = {pc_out, a0, a1, a2, imm, func, dut_en, ld_code, illegal};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written from the RV32I field rules with integer math.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int   s, hi, v_i, v_s, v_b, v_j;
    logic [31:0] v_u;
    logic [9:0]  ffull;
    logic        wr;
    s     = $signed(ins);
    hi    = s >>> 31;
    v_i   = s >>> 20;
    v_s   = (s >>> 25) * 32 + int'(ins[11:7]);
    v_b   = hi * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    v_j   = hi * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
    v_u   = {ins[31:12], 12'h000};
    ffull = {ins[31:25], ins[14:12]};
    wr    = (ins[11:7] != 5'd0);
    e        = '0;
    e.pc     = pc;
    e.a0     = ins[19:15];
    e.a1     = ins[24:20];
    e.a2     = ins[11:7];
    e.chk_fi = 1'b1;
    if (ins[1:0] != 2'b11) begin
      e.ill = 1'b1; e.chk_fi = 1'b0;
    end else begin
      case (ins[6:0])
        7'h37: begin e.imm = v_u; e.ld = 3'd3; e.en = {4'b0000, wr, 1'b0}; end
        7'h17: begin e.imm = v_u; e.ld = 3'd5; e.en = {4'b0000, wr, 1'b0}; end
        7'h6F: begin e.imm = v_j; e.ld = 3'd4; e.en = {4'b1101, wr, 1'b0}; end
        7'h67: begin e.imm = v_i; e.ld = 3'd4; e.func = ffull; e.en = {4'b1011, wr, 1'b0}; end
        7'h03: begin e.imm = v_i; e.ld = 3'd2; e.en = {4'b0001, wr, 1'b0}; end
        7'h23: begin e.imm = v_s; e.ld = 3'd0; e.en = 6'b000101; end
        7'h63: begin e.imm = v_b; e.ld = 3'd0; e.func = ffull; e.en = 6'b100000; end
        7'h13: begin
          e.imm = v_i; e.ld = 3'd1; e.en = {4'b0001, wr, 1'b0};
          e.func = (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ? ffull : {7'd0, ins[14:12]};
        end
        7'h33: begin e.imm = 0; e.ld = 3'd1; e.func = ffull; e.en = {4'b0000, wr, 1'b0}; end
        7'h0F, 7'h73: begin e.chk_fi = 1'b0; end
        default: begin e.ill = 1'b1; e.chk_fi = 1'b0; end
      endcase
    end
    return e;
  endfunction

  logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h13, 7'h33, 7'h0F, 7'h73};

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int          r;
    ins = $urandom;
    r   = $urandom_range(0, 13);
    if (r == 11) ins[6:0] = 7'($urandom_range(0, 127));
    else begin
      ins[6:0] = ops[$urandom_range(0, 10)];
      if (r == 12) ins[1:0] = 2'($urandom_range(0, 2));
    end
    if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
    return ins;
  endfunction

  // One clock cycle of stimulus; starts and ends 1 time unit after a rising edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    in_valid = v; instr = ins; pc_in = pc; out_ready = ordy; flush = fl;
    @(negedge clk); #1;
    if (fl) sb.delete();
    else if (v && in_ready) sb.push_back(model(ins, pc));
    @(posedge clk); #1;
  endtask

  // Monitor: occupancy, hold stability and in-order bundle content.
  logic        hold_pend = 1'b0;
  logic [98:0] held;
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      exp_t e;
      chk("out_valid_occupancy", out_valid, sb.size() != 0);
      chk("in_ready_occupancy", in_ready, sb.size() < 2);
      if (hold_pend) chk("bundle_stable", cur_bundle, held);
      hold_pend = out_valid && !out_ready && !flush;
      held      = cur_bundle;
      if (!flush && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_bundle", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("pc_out", pc_out, e.pc);
          chk("a0", a0, e.a0);
          chk("a1", a1, e.a1);
          chk("a2", a2, e.a2);
          chk("enables", dut_en, e.en);
          chk("ld_code", ld_code, e.ld);
          chk("illegal", illegal, e.ill);
          if (e.chk_fi) begin
            chk("imm", imm, e.imm);
            chk("func", func, e.func);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; pc_in = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_bundle", cur_bundle, 0);
    rst = 1'b0;

    // ADDI x1, x0, 5 accepted straight after reset
    step(1, 32'h00500093, 32'h100, 1, 0);
    chk("addi_valid", out_valid, 1);
    chk("addi_a2", a2, 1);
    chk("addi_a0", a0, 0);
    chk("addi_imm", imm, 5);
    chk("addi_ld", ld_code, 3'b001);
    chk("addi_en_imm", en_imm, 1);
    chk("addi_en_reg_wr", en_reg_wr, 1);
    chk("addi_pc", pc_out, 32'h100);

    // BEQ x1, x2, -4
    step(1, 32'hFE208EE3, 32'h104, 1, 0);
    chk("br_imm", imm, 32'hFFFF_FFFC);
    chk("br_en_jmp", en_jmp, 1);
    chk("br_en_reg_wr", en_reg_wr, 0);
    chk("br_ld", ld_code, 0);
    chk("br_a0", a0, 1);
    chk("br_a1", a1, 2);

    // JAL x0, +8
    step(1, 32'h0080006F, 32'h108, 1, 0);
    chk("jal_imm", imm, 8);
    chk("jal_uncond", en_uncond_jmp, 1);
    chk("jal_en_reg_wr", en_reg_wr, 0);
    chk("jal_ld", ld_code, 3'b100);

    // Unsupported opcode
    step(1, 32'h0000007F, 32'h10C, 1, 0);
    chk("ill_flag", illegal, 1);
    chk("ill_enables", dut_en, 0);
    chk("ill_ld", ld_code, 0);
    step(0, 0, 0, 1, 0);

    // Backpressure: three back-to-back offers with out_ready low
    step(1, 32'h00100093, 32'h1, 0, 0);
    step(1, 32'h00200093, 32'h2, 0, 0);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_first_out", pc_out, 32'h1);
    step(1, 32'h00300093, 32'h3, 1, 0);
    chk("bp_second_out", pc_out, 32'h2);
    step(1, 32'h00300093, 32'h3, 1, 0);
    chk("bp_third_out", pc_out, 32'h3);
    step(0, 0, 0, 1, 0);
    chk("bp_drained", out_valid, 0);

    // Flush while full with a valid input
    step(1, 32'h00A00093, 32'h200, 0, 0);
    step(1, 32'h00B00093, 32'h204, 0, 0);
    step(1, 32'h00C00093, 32'h208, 0, 1);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    step(0, 0, 0, 1, 0);
    chk("flush_input_dropped", out_valid, 0);

    // Asynchronous reset while full
    step(1, 32'h00500093, 32'h300, 0, 0);
    step(1, 32'h00700093, 32'h304, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_imm", imm, 0);
    chk("rst_mid_illegal", illegal, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    step(1, 32'h00500093, 32'h400, 1, 0);
    chk("post_rst_accept", out_valid, 1);

    // Random traffic
    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), pc, $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0);
      pc = pc + 4;
    end
    repeat (4) step(0, 0, 0, 1, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, the width of imm, pc_in and pc_out; legal range is 32 or more; immediates sign-extend to XLEN.
REQ-002 SHALL have parameter EN_SYSTEM, default 1: 1 decodes FENCE (0001111) and SYSTEM (1110011) as legal no-ops; 0 flags them illegal.
REQ-003 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port flush, input, 1 bit: synchronous pipeline clear.
REQ-006 SHALL have port in_valid, input, 1 bit: an upstream instruction is present.
REQ-007 SHALL have port in_ready, output, 1 bit: the stage can accept an instruction.
REQ-008 SHALL have port instr, input, 32 bits: the RV32I instruction word.
REQ-009 SHALL have port pc_in, input, XLEN bits: the instruction address.
REQ-010 SHALL have port out_valid, output, 1 bit: a decoded bundle is present.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the bundle.
REQ-012 SHALL have port pc_out, output, XLEN bits: pc_in, carried with its bundle.
REQ-013 SHALL have ports a0, a1 and a2, outputs, 5 bits each: instr[19:15] (rs1), instr[24:20] (rs2) and instr[11:7] (rd).
REQ-014 SHALL have port imm, output, XLEN bits: the format-selected, sign-extended immediate.
REQ-015 SHALL have port func, output, 10 bits: {instr[31:25], instr[14:12]}.
REQ-016 SHALL have ports en_jmp, en_uncond_jmp, en_rel_reg_jmp, en_imm, en_reg_wr and en_mem_wr, outputs, 1 bit each: control enables.
REQ-017 SHALL have port ld_code, output, 3 bits: writeback source; NO 000, ALU 001, MEM 010, IMM 011, PC 100, PC+IMM 101.
REQ-018 SHALL have port illegal, output, 1 bit: the opcode is unsupported.

Function
REQ-019 SHALL accept an instruction (in_fire) when in_valid=1 and in_ready=1, and SHALL complete a bundle (out_fire) when out_valid=1 and out_ready=1.
REQ-020 SHALL register all outputs: a bundle accepted in cycle N appears in cycle N+1; sustained throughput is 1 per cycle.
REQ-021 SHALL contain an output register plus a 1-entry skid register, giving 3 states: EMPTY, ONE and FULL.
REQ-022 SHALL drive in_ready = ~skid_valid as a registered value, with no combinational path from out_ready.
REQ-023 Transitions SHALL be:
- EMPTY + in_fire -> ONE.
- ONE + in_fire without out_fire -> FULL, with the new bundle stored in skid.
- ONE + out_fire without in_fire -> EMPTY.
- FULL + out_fire -> ONE, with skid moving to the output.
- All other combinations hold state.
REQ-024 In ONE, simultaneous in_fire and out_fire SHALL load the new bundle into the output register and stay in ONE.
REQ-025 SHALL keep the output bundle stable while out_valid=1 and out_ready=0.
REQ-026 SHALL deliver bundles in acceptance order, with no loss and no duplication.
REQ-027 flush=1 SHALL force the state to EMPTY at the next edge and SHALL drop any in_fire in the same cycle; flush takes priority over all other events.
REQ-028 SHALL decode per opcode as follows (en_rel_reg_jmp=0 and en_mem_wr=0 unless stated):
- LUI: U-type; IMM; en_reg_wr=1.
- AUIPC: U-type; PC+IMM; en_reg_wr=1.
- JAL: J-type; PC; en_jmp=1, en_uncond_jmp=1, en_imm=1, en_reg_wr=1.
- JALR: I-type; PC; en_jmp=1, en_rel_reg_jmp=1, en_imm=1, en_reg_wr=1.
- LOAD: I-type; MEM; en_imm=1, en_reg_wr=1.
- STORE: S-type; NO; en_imm=1, en_mem_wr=1.
- BRANCH: B-type; NO; en_jmp=1, en_reg_wr=0.
- OP-IMM: I-type; ALU; en_imm=1, en_reg_wr=1.
- OP: no immediate; ALU; en_reg_wr=1.
REQ-029 SHALL drive unlisted outputs to 0 and every enable explicitly for every opcode, with no retained values.
REQ-030 SHALL force en_reg_wr=0 when rd=0 for every opcode.
REQ-031 SHALL zero func for LOAD, STORE, LUI, AUIPC and JAL.
REQ-032 For OP-IMM, SHALL zero func[9:3] unless funct3 is 001 or 101.
REQ-033 Immediates SHALL be:
- U: {instr[31:12], 12'b0}.
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- All formats except U SHALL be sign-extended to XLEN; for OP, imm=0.
REQ-034 An unrecognised opcode, or instr[1:0]!=11, SHALL give illegal=1, all enables 0 and ld_code=000, and SHALL still flow through the handshake.

Reset
REQ-035 While rst=1, SHALL immediately set state EMPTY, out_valid=0, in_ready=1, and all bundle outputs (pc_out, a0-a2, imm, func, enables, ld_code, illegal) to 0.
REQ-036 On rst deassertion, the first in_fire SHALL be accepted with no extra wait cycles.

Verification
REQ-037 Reset: rst=1 mid-stream with FULL state -> same cycle out_valid=0, in_ready=1, imm=0, illegal=0.
REQ-038 ADDI: instr=00500093, pc_in=0x100, out_ready=1 -> next cycle out_valid=1, a2=1, a0=0, imm=5, ld_code=001, en_imm=1, en_reg_wr=1, pc_out=0x100.
REQ-039 Branch: instr=FE208EE3 -> imm=FFFFFFFC, en_jmp=1, en_reg_wr=0, ld_code=000, a0=1, a1=2.
REQ-040 JAL x0: instr=0080006F -> imm=8, en_uncond_jmp=1, en_reg_wr=0, ld_code=100.
REQ-041 Backpressure: out_ready=0, 3 instructions offered back-to-back -> in_ready=0 after 2 accepts; with out_ready=1 afterwards, the output order is 1, 2, 3 with no loss.
REQ-042 Illegal/flush: instr=0000007F -> illegal=1, all enables 0; flush=1 in FULL state with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the input is dropped.
